// File: rtl/ctrl_main_fsm.sv
// Camera main sequencer: IDLE -> EXPOSURE -> READOUT -> IDLE once per start
// request. Consumes the exposure time from ctrl_ex_time and drives the
// pixel-array strobes (Erase, Expose, NRE_1/NRE_2, ADC) as a Moore machine.
module ctrl_main_fsm #(
  parameter int EXP_PRESCALE = 4,
  parameter int CNT_W        = 5
) (
  input  logic             i_Clock,
  input  logic             i_Reset,
  input  logic             i_Init,
  input  logic [CNT_W-1:0] i_count_time,
  output logic [1:0]       o_Main_FSM,
  output logic             o_Erase,
  output logic             o_Expose,
  output logic             o_NRE_1,
  output logic             o_NRE_2,
  output logic             o_ADC
);

  // Longest exposure is (2^CNT_W-1)*EXP_PRESCALE cycles; the down-counter
  // holds that length minus one, so this width never wraps.
  localparam int EXP_MAX = ((2 ** CNT_W) - 1) * EXP_PRESCALE;
  localparam int EXP_W   = $clog2(EXP_MAX + 1);
  localparam logic [EXP_W-1:0] PRESC = EXP_W'(EXP_PRESCALE);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_EXPOSE  = 2'b01,
    ST_READOUT = 2'b10
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [EXP_W-1:0] r_exp_cnt;
  logic [EXP_W-1:0] w_exp_next;
  logic [2:0]       r_rd_cnt;
  logic [2:0]       w_rd_next;
  logic [CNT_W-1:0] w_n;
  logic [EXP_W-1:0] w_exp_load;

  // A zero exposure setting is treated as one unit; the counter is loaded
  // with the total cycle count minus one and runs down to zero.
  assign w_n        = (i_count_time == '0) ? CNT_W'(1) : i_count_time;
  assign w_exp_load = (EXP_W'(w_n) * PRESC) - EXP_W'(1);

  // State and counter registers; reset returns everything to IDLE.
  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      r_state   <= ST_IDLE;
      r_exp_cnt <= '0;
      r_rd_cnt  <= '0;
    end else begin
      r_state   <= w_state_next;
      r_exp_cnt <= w_exp_next;
      r_rd_cnt  <= w_rd_next;
    end
  end

  // Next-state/counter logic and Moore output decode from registered state.
  always_comb begin
    w_state_next = r_state;
    w_exp_next   = r_exp_cnt;
    w_rd_next    = r_rd_cnt;
    o_Main_FSM   = 2'b00;
    o_Erase      = 1'b1;
    o_Expose     = 1'b0;
    o_NRE_1      = 1'b1;
    o_NRE_2      = 1'b1;
    o_ADC        = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_rd_next = '0;
        if (i_Init) begin
          w_state_next = ST_EXPOSE;
          w_exp_next   = w_exp_load;
        end
      end

      ST_EXPOSE: begin
        o_Main_FSM = 2'b01;
        o_Erase    = 1'b0;
        o_Expose   = 1'b1;
        if (r_exp_cnt == '0) begin
          w_state_next = ST_READOUT;
          w_rd_next    = '0;
        end else begin
          w_exp_next = r_exp_cnt - EXP_W'(1);
        end
      end

      ST_READOUT: begin
        o_Main_FSM = 2'b10;
        o_Erase    = 1'b0;
        // Row 1 occupies r=0..2, row 2 r=4..6; r=3 and r=7 are guard slots
        // so the two enables never overlap. ADC fires mid-window.
        case (r_rd_cnt)
          3'd0, 3'd2: o_NRE_1 = 1'b0;
          3'd1: begin
            o_NRE_1 = 1'b0;
            o_ADC   = 1'b1;
          end
          3'd4, 3'd6: o_NRE_2 = 1'b0;
          3'd5: begin
            o_NRE_2 = 1'b0;
            o_ADC   = 1'b1;
          end
          default: ;
        endcase
        if (r_rd_cnt == 3'd7) begin
          w_state_next = ST_IDLE;
          w_rd_next    = '0;
        end else begin
          w_rd_next = r_rd_cnt + 3'd1;
        end
      end

      default: begin
        // Unreachable code 11: recover to IDLE, outputs stay at reset values.
        w_state_next = ST_IDLE;
        w_exp_next   = '0;
        w_rd_next    = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_ctrl_main_fsm.sv
// Self-checking bench for ctrl_main_fsm: a frame-level model expands each
// accepted start request into its expected per-cycle output vectors, and a
// compare process checks the DUT against it every cycle. Directed scenarios
// add literal expectations on exposure/readout lengths.
module tb_ctrl_main_fsm;
  localparam int P  = 4;
  localparam int CW = 5;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          init  = 1'b0;
  logic [CW-1:0] ct    = '0;
  logic [1:0]    o_main;
  logic          o_erase, o_expose, o_nre1, o_nre2, o_adc;

  always #5 clk = ~clk;

  ctrl_main_fsm #(.EXP_PRESCALE(P), .CNT_W(CW)) dut (
    .i_Clock      (clk),
    .i_Reset      (rst_n),
    .i_Init       (init),
    .i_count_time (ct),
    .o_Main_FSM   (o_main),
    .o_Erase      (o_erase),
    .o_Expose     (o_expose),
    .o_NRE_1      (o_nre1),
    .o_NRE_2      (o_nre2),
    .o_ADC        (o_adc)
  );

  // Output vector: {main[1:0], erase, expose, nre1, nre2, adc}
  wire [6:0] w_dut = {o_main, o_erase, o_expose, o_nre1, o_nre2, o_adc};

  localparam logic [6:0] V_IDLE = 7'b00_1_0_1_1_0;
  localparam logic [6:0] V_EXP  = 7'b01_0_1_1_1_0;
  logic [6:0] RO [8] = '{7'b10_0_0_0_1_0, 7'b10_0_0_0_1_1, 7'b10_0_0_0_1_0,
                         7'b10_0_0_1_1_0, 7'b10_0_0_1_0_0, 7'b10_0_0_1_0_1,
                         7'b10_0_0_1_0_0, 7'b10_0_0_1_1_0};

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame model: a start accepted from IDLE queues N*P exposure vectors and
  // the 8-entry readout schedule; with nothing queued the sequencer idles.
  logic [6:0] q[$];
  logic [6:0] m_cur = V_IDLE;
  int         m_n;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_cur = V_IDLE;
    end else begin
      if (q.size() == 0 && m_cur == V_IDLE && init) begin
        m_n = (ct == 0) ? 1 : int'(ct);
        for (int i = 0; i < m_n * P; i++) q.push_back(V_EXP);
        for (int r = 0; r < 8; r++) q.push_back(RO[r]);
      end
      if (q.size() > 0) m_cur = q.pop_front();
      else m_cur = V_IDLE;
    end
  end

  // Per-cycle comparison against the model plus strobe invariants.
  always @(negedge clk) begin
    chk("cycle_vs_model", w_dut, m_cur);
    chk("nre_overlap", (!o_nre1 && !o_nre2), 0);
    chk("adc_without_single_nre", (o_adc && !(o_nre1 ^ o_nre2)), 0);
  end

  task automatic run_frame(input logic [CW-1:0] t, input int change_at,
                           input logic [CW-1:0] t2, input int exp_len, input string tag);
    int e = 0, r = 0, a = 0, n1 = 0, n2 = 0, cyc = 0;
    bit seen_ro = 0, done = 0;
    @(posedge clk); #2 ct = t; init = 1'b1;
    @(posedge clk); #2 init = 1'b0;
    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (o_expose) e++;
      if (o_main == 2'b10) begin
        r++;
        seen_ro = 1;
        if (o_adc) a++;
        if (!o_nre1) n1++;
        if (!o_nre2) n2++;
      end
      if (seen_ro && o_main == 2'b00) done = 1;
      if (cyc == change_at) ct = t2;
    end
    chk({tag, "_completed"}, done, 1);
    chk({tag, "_expose_len"}, e, exp_len);
    chk({tag, "_readout_len"}, r, 8);
    chk({tag, "_adc_pulses"}, a, 2);
    chk({tag, "_nre1_low"}, n1, 3);
    chk({tag, "_nre2_low"}, n2, 3);
  endtask

  initial begin
    int starts, idles, cyc;
    logic [1:0] prev;
    bit found;

    // Reset held, then released mid-cycle with i_Init low.
    ct = 5'd5;
    @(negedge clk); chk("reset_active", w_dut, 7'b0010110);
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk); chk("reset_hold", w_dut, 7'b0010110);
    end

    run_frame(5'd5, 0, 5'd5, 20, "ct5");
    run_frame(5'd5, 3, 5'd30, 20, "ct5_to_30");
    run_frame(5'd0, 0, 5'd0, 4, "ct0");
    run_frame(5'd31, 0, 5'd31, 124, "ct31");

    // Init held high: three back-to-back frames with one IDLE cycle between.
    @(posedge clk); #2 ct = 5'd2; init = 1'b1;
    starts = 0; idles = 0; cyc = 0; prev = o_main;
    while (starts < 3 && cyc < 600) begin
      @(negedge clk);
      cyc++;
      if (o_main == 2'b01 && prev != 2'b01) starts++;
      else if (starts >= 1 && o_main == 2'b00) idles++;
      prev = o_main;
    end
    chk("held_init_frames", starts, 3);
    chk("held_init_idle_cycles", idles, 2);
    @(posedge clk); #2 init = 1'b0;
    cyc = 0;
    while (o_main != 2'b00 && cyc < 100) begin
      @(negedge clk); cyc++;
    end
    chk("held_init_drain", o_main, 2'b00);

    // Asynchronous reset at readout slot r=3.
    @(posedge clk); #2 ct = 5'd1; init = 1'b1;
    @(posedge clk); #2 init = 1'b0;
    found = 0; cyc = 0;
    while (!found && cyc < 50) begin
      @(negedge clk); cyc++;
      if (o_main == 2'b10 && o_nre1 && o_nre2) found = 1;
    end
    chk("reach_r3", found, 1);
    #1 rst_n = 1'b0;
    #1 chk("async_reset_immediate", w_dut, 7'b0010110);
    repeat (2) @(negedge clk);
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk); chk("post_abort_idle", w_dut, 7'b0010110);
    end
    run_frame(5'd2, 0, 5'd2, 8, "after_reset");

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
